imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface: receives a program as a byte stream from a host
//  (valid/ready), packs bytes into 32-bit words and writes them into instruction memory via a write port.
//  Holds the pipeline (out_cpu_hold) from start of load until a verified image is in place.
//  Sits beside fetch; shares instruction memory with it. Fetch reads, this block writes.
// PARAMETERS
//  BASE_ADDR  32'd0   byte address of first word written; must be word-aligned
//  MAX_WORDS  256     largest accepted word count; larger header -> error
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   asynchronous, active-low reset
//  in_start         in   1   1-cycle pulse; begins a load (ignored while busy)
//  in_byte_valid    in   1   host byte valid
//  in_byte          in   8   host byte
//  out_byte_ready   out  1   loader accepts in_byte this cycle (transfer = valid & ready)
//  out_we           out  1   instruction-memory write strobe, 1-cycle pulse
//  out_addr         out  32  write byte address
//  out_wdata        out  32  write word
//  out_cpu_hold     out  1   hold pipeline PC/registers
//  out_busy         out  1   load in progress
//  out_done         out  1   last load completed with good checksum (sticky)
//  out_error        out  1   last load failed (sticky)
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; all outputs 0; word/byte counters and checksum cleared.
//  Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N data bytes (each word little-endian:
//   first byte -> wdata[7:0]), then 1 checksum byte = XOR of all preceding frame bytes incl. length.
//  States: IDLE -> (in_start) LEN_LO -> LEN_HI -> DATA -> WRITE -> DATA ... -> CHECK -> DONE | ERR.
//   IDLE: ready=0. in_start clears done/error/counters/checksum, sets busy=1, cpu_hold=1.
//   LEN_LO/LEN_HI/DATA/CHECK: ready=1; advance only on a transfer. Checksum XORs in every transfer.
//   After LEN_HI: N==0 -> CHECK; N>MAX_WORDS -> ERR; else DATA.
//   DATA: 4th byte of a word -> WRITE. WRITE (ready=0, exactly 1 cycle): out_we=1,
//    out_addr=BASE_ADDR+4*word_idx, out_wdata=assembled word; word_idx+1; if word_idx==N-1 -> CHECK else DATA.
//   CHECK: byte==checksum -> DONE else ERR.
//   DONE: busy=0, done=1, cpu_hold=0, return to IDLE next cycle (done stays sticky).
//   ERR:  busy=0, error=1, cpu_hold stays 1 (bad image never runs); to IDLE; next in_start retries.
//  Latency: out_we asserted the cycle after the 4th byte of a word transfers; min 5 cycles/word.
//  out_addr/out_wdata hold last written value when out_we=0. word_idx is 16 bits; no wrap (bounded by MAX_WORDS).
//  in_start while busy: ignored. in_byte_valid in IDLE/WRITE: not consumed (ready=0), host must hold.
//  Reset mid-load: immediate return to IDLE, cpu_hold released; partial image left in memory.
// STRUCTURE
//  loader_pkg: state encoding (IDLE..ERR), LEN_BYTES=2, BYTES_PER_WORD=4, frame field constants.
//  Sub-module loader_word_assembler: 2-bit byte counter + 32-bit shift/pack register; outputs word and
//   word_full; cleared by FSM on start. FSM, counters, checksum and write port stay in imem_loader.
// TESTING
//  1 N=2, words 0x8C010004,0x00221820, correct checksum -> 2 we pulses: addr 0x0/0x4, data as sent; done=1.
//  2 Checksum byte XORed with 0x01 -> both words written, error=1, done=0, cpu_hold stays 1.
//  3 Header N=0x0101 (>256) -> ERR right after LEN_HI, no we pulse, ready=0 afterwards.
//  4 N=0, checksum=0x00 -> no writes, done=1, cpu_hold drops 2 cycles after checksum transfer.
//  5 Random valid gaps + in_start pulse mid-load -> start ignored, data/addresses unchanged vs test 1.
//  6 reset low after 5 data bytes of N=3 -> outputs 0 asynchronously; new start+full frame loads cleanly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package imem_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = LEN_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic error;
        logic cpu_hold;
    } status_t;

    // Byte address of word idx; idx is a word count, so shift by log2(BYTES_PER_WORD).
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                     input logic [LEN_W-1:0]  idx);
        return base + {{(WORD_W-LEN_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and loader status, bundled.
// Latency: n/a (wiring only).
// Backpressure: in_byte_valid held by host until out_byte_ready.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic                in_start;
    logic                in_byte_valid;
    logic [BYTE_W-1:0]   in_byte;
    logic                out_byte_ready;
    logic                out_we;
    logic [WORD_W-1:0]   out_addr;
    logic [WORD_W-1:0]   out_wdata;
    logic                out_cpu_hold;
    logic                out_busy;
    logic                out_done;
    logic                out_error;

    modport master (
        output in_start, in_byte_valid, in_byte,
        input  out_byte_ready, out_we, out_addr, out_wdata,
               out_cpu_hold, out_busy, out_done, out_error
    );

    modport slave (
        input  in_start, in_byte_valid, in_byte,
        output out_byte_ready, out_we, out_addr, out_wdata,
               out_cpu_hold, out_busy, out_done, out_error
    );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into a word; first byte lands in word[7:0].
// Latency: combinational; word/word_full valid in the cycle the last byte is pushed.
// Backpressure: none, pushes are gated by the owner.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              push,
    input  logic [BYTE_W-1:0] byte_dat,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam int SR_W  = WORD_W - BYTE_W;

    logic [CNT_W-1:0] cnt_q;
    logic [SR_W-1:0]  sr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (clr) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (push) begin
            cnt_q <= cnt_q + CNT_W'(1);
            sr_q  <= {byte_dat, sr_q[SR_W-1:BYTE_W]};
        end
    end

    // The completing byte is folded in combinationally so the owner can capture the word on that transfer.
    assign word      = {byte_dat, sr_q};
    assign word_full = push && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Receives a length/data/checksum byte frame and writes it into instruction memory, holding the CPU meanwhile.
// Latency: write strobe one cycle after the 4th byte of a word; at least 5 cycles per word.
// Backpressure: out_byte_ready low in IDLE/WRITE/DONE/ERR; host holds its byte until accepted.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'd0,
    parameter int                MAX_WORDS = 256
)
(
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    localparam logic [LEN_W:0] MAX_W = (LEN_W+1)'(MAX_WORDS);

    state_t            state_q, state_d;
    status_t           stat_q;
    logic [BYTE_W-1:0] len_lo_q;
    logic [BYTE_W-1:0] csum_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_idx_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;

    logic [LEN_W-1:0]  len_d;
    logic              byte_rdy;
    logic              xfer;
    logic              start_acc;
    logic              write_en;
    logic              asm_push;
    logic              asm_full;
    logic [WORD_W-1:0] asm_word;
    logic              last_word;

    assign byte_rdy  = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK};
    assign xfer      = bus.in_byte_valid && byte_rdy;
    assign len_d     = {bus.in_byte, len_lo_q};
    assign asm_push  = xfer && (state_q == ST_DATA);
    assign last_word = (word_idx_q + LEN_W'(1)) == len_q;

    imem_loader_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_acc),
        .push      (asm_push),
        .byte_dat  (bus.in_byte),
        .word      (asm_word),
        .word_full (asm_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        write_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_start) begin
                    start_acc = 1'b1;
                    state_d   = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    if (len_d == '0)
                        state_d = ST_CHECK;
                    else if ({1'b0, len_d} > MAX_W)
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (asm_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                write_en = 1'b1;
                state_d  = last_word ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
                if (xfer) state_d = (bus.in_byte == csum_q) ? ST_DONE : ST_ERR;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_q     <= '0;
            len_lo_q   <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            word_idx_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            if (start_acc) begin
                stat_q     <= '{busy: 1'b1, done: 1'b0, error: 1'b0, cpu_hold: 1'b1};
                len_lo_q   <= '0;
                len_q      <= '0;
                csum_q     <= '0;
                word_idx_q <= '0;
            end
            // Running XOR excludes the byte being checked: CHECK compares against csum_q before the update.
            if (xfer) csum_q <= csum_q ^ bus.in_byte;
            if (xfer && state_q == ST_LEN_LO) len_lo_q <= bus.in_byte;
            if (xfer && state_q == ST_LEN_HI) len_q <= len_d;
            if (asm_full) begin
                addr_q  <= word_addr(BASE_ADDR, word_idx_q);
                wdata_q <= asm_word;
            end
            if (state_q == ST_WRITE) word_idx_q <= word_idx_q + LEN_W'(1);
            if (state_q == ST_DONE) begin
                stat_q.busy     <= 1'b0;
                stat_q.done     <= 1'b1;
                stat_q.cpu_hold <= 1'b0;
            end
            // A failed image keeps the CPU held so it never executes.
            if (state_q == ST_ERR) begin
                stat_q.busy  <= 1'b0;
                stat_q.error <= 1'b1;
            end
        end
    end

    assign bus.out_byte_ready = byte_rdy;
    assign bus.out_we         = write_en;
    assign bus.out_addr       = addr_q;
    assign bus.out_wdata      = wdata_q;
    assign bus.out_busy       = stat_q.busy;
    assign bus.out_done       = stat_q.done;
    assign bus.out_error      = stat_q.error;
    assign bus.out_cpu_hold   = stat_q.cpu_hold;

    a_we_pulse: assert property (@(posedge clk) disable iff (!reset) bus.out_we |=> !bus.out_we);
    a_we_align: assert property (@(posedge clk) disable iff (!reset) bus.out_we |-> (bus.out_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_imem_loader.sv
// Directed frames for imem_loader checked against a frame-level model of expected writes and status.
module tb_imem_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    imem_loader_if bus();

    imem_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(256)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          total = 0;
    int          bad   = 0;
    bit          sim_end = 1'b0;
    logic [7:0]  frame[$];
    logic [31:0] words_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] exp_last_addr = 32'd0;
    logic [31:0] exp_last_data = 32'd0;
    logic [7:0]  model_csum = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, 32'({bus.out_we, bus.out_byte_ready, bus.out_busy,
                                     bus.out_done, bus.out_error, bus.out_cpu_hold}), 32'd0);
        check({name, "_addr"}, bus.out_addr, 32'd0);
        check({name, "_wdata"}, bus.out_wdata, 32'd0);
    endtask

    // Frame = len_lo, len_hi, little-endian words, XOR checksum (optionally corrupted).
    task automatic build_frame(input logic [15:0] n_hdr, input bit corrupt);
        logic [7:0] cs;
        frame.delete();
        frame.push_back(n_hdr[7:0]);
        frame.push_back(n_hdr[15:8]);
        foreach (words_q[w])
            for (int b = 0; b < 4; b++) frame.push_back(words_q[w][8*b +: 8]);
        cs = 8'd0;
        foreach (frame[i]) cs = cs ^ frame[i];
        frame.push_back(corrupt ? (cs ^ 8'h01) : cs);
    endtask

    // Decides from the frame alone which writes must appear and how the load ends.
    task automatic model_eval(output int nb, output bit e_done, output bit e_err);
        int         n;
        logic [7:0] cs;
        exp_addr_q.delete();
        exp_data_q.delete();
        n = int'(frame[0]) + 256 * int'(frame[1]);
        if (n > 256) begin
            nb = 2; e_done = 1'b0; e_err = 1'b1;
        end else begin
            cs = 8'd0;
            for (int i = 0; i < 2 + 4*n; i++) cs = cs ^ frame[i];
            model_csum = cs;
            for (int w = 0; w < n; w++) begin
                exp_addr_q.push_back(32'd0 + 32'(4*w));
                exp_data_q.push_back({frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]});
            end
            nb     = 3 + 4*n;
            e_done = (frame[2+4*n] == cs);
            e_err  = !e_done;
        end
    endtask

    task automatic pulse_start();
        bus.in_start = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.in_byte_valid = 1'b1;
        bus.in_byte       = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.out_byte_ready) begin ok = 1'b1; break; end
        end
        check("byte_accepted", 32'(ok), 32'd1);
        if (ok) begin @(posedge clk); #1; end
        bus.in_byte_valid = 1'b0;
    endtask

    task automatic run_frame(input bit gaps, input int start_at, input int limit,
                             output bit e_done, output bit e_err);
        int nb;
        model_eval(nb, e_done, e_err);
        pulse_start();
        for (int i = 0; i < nb && i < limit; i++) begin
            if (i == start_at) pulse_start();
            send_byte(frame[i], gaps);
        end
    endtask

    task automatic finish_test(input string name, input bit e_done, input bit e_err);
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!bus.out_busy) begin ok = 1'b1; break; end
        end
        check({name, "_idle"}, 32'(ok), 32'd1);
        check({name, "_done"}, 32'(bus.out_done), 32'(e_done));
        check({name, "_error"}, 32'(bus.out_error), 32'(e_err));
        check({name, "_hold"}, 32'(bus.out_cpu_hold), 32'(e_err));
        check({name, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_t1_log(input string name);
        check({name, "_nwr"}, 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check({name, "_a0"}, log_addr[0], 32'h0000_0000);
            check({name, "_d0"}, log_data[0], 32'h8C01_0004);
            check({name, "_a1"}, log_addr[1], 32'h0000_0004);
            check({name, "_d1"}, log_data[1], 32'h0022_1820);
        end
    endtask

    initial begin
        bus.in_start      = 1'b0;
        bus.in_byte_valid = 1'b0;
        bus.in_byte       = 8'd0;
        fork
            begin : monitor
                logic prev_we;
                prev_we = 1'b0;
                while (!sim_end) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        check_all_zero("mon_reset");
                        prev_we = 1'b0;
                    end else begin
                        check("ready_implies_busy", 32'(bus.out_byte_ready & ~bus.out_busy), 32'd0);
                        if (bus.out_we) begin
                            check("we_single_cycle", 32'(prev_we), 32'd0);
                            log_addr.push_back(bus.out_addr);
                            log_data.push_back(bus.out_wdata);
                            if (exp_addr_q.size() == 0) begin
                                check("unexpected_we", 32'd1, 32'd0);
                            end else begin
                                exp_last_addr = exp_addr_q.pop_front();
                                exp_last_data = exp_data_q.pop_front();
                                check("wr_addr", bus.out_addr, exp_last_addr);
                                check("wr_data", bus.out_wdata, exp_last_data);
                            end
                        end else begin
                            check("held_addr", bus.out_addr, exp_last_addr);
                            check("held_wdata", bus.out_wdata, exp_last_data);
                        end
                        prev_we = bus.out_we;
                    end
                end
            end
            begin : stimulus
                bit ed, ee, seen;
                #2;
                check_all_zero("reset_init");
                #10 rst_n = 1'b1;
                @(posedge clk); #1;

                // 1: two-word image, good checksum
                words_q = '{32'h8C01_0004, 32'h0022_1820};
                build_frame(16'd2, 1'b0);
                log_addr.delete(); log_data.delete();
                run_frame(1'b0, -1, 1000, ed, ee);
                check("t1_model_csum", 32'(model_csum), 32'h91);
                finish_test("t1", ed, ee);
                check("t1_done_lit", 32'(bus.out_done), 32'd1);
                check_t1_log("t1");

                // 2: corrupted checksum
                build_frame(16'd2, 1'b1);
                log_addr.delete(); log_data.delete();
                run_frame(1'b0, -1, 1000, ed, ee);
                finish_test("t2", ed, ee);
                check("t2_error_lit", 32'({bus.out_error, bus.out_done, bus.out_cpu_hold}), 32'b101);
                check_t1_log("t2");

                // 3: oversize header
                words_q.delete();
                build_frame(16'h0101, 1'b0);
                log_addr.delete(); log_data.delete();
                run_frame(1'b0, -1, 1000, ed, ee);
                seen = 1'b0;
                repeat (4) begin @(negedge clk); seen = seen | bus.out_byte_ready; end
                check("t3_ready_after_err", 32'(seen), 32'd0);
                @(posedge clk); #1;
                finish_test("t3", ed, ee);
                check("t3_nwr", 32'(log_addr.size()), 32'd0);

                // 4: empty image
                build_frame(16'd0, 1'b0);
                log_addr.delete(); log_data.delete();
                run_frame(1'b0, -1, 1000, ed, ee);
                @(negedge clk);
                check("t4_hold_cycle1", 32'(bus.out_cpu_hold), 32'd1);
                @(negedge clk);
                check("t4_hold_cycle2", 32'(bus.out_cpu_hold), 32'd0);
                @(posedge clk); #1;
                finish_test("t4", ed, ee);
                check("t4_done_lit", 32'(bus.out_done), 32'd1);
                check("t4_nwr", 32'(log_addr.size()), 32'd0);

                // 5: valid gaps and a stray start pulse mid-frame
                words_q = '{32'h8C01_0004, 32'h0022_1820};
                build_frame(16'd2, 1'b0);
                log_addr.delete(); log_data.delete();
                run_frame(1'b1, 5, 1000, ed, ee);
                finish_test("t5", ed, ee);
                check_t1_log("t5");

                // 6: reset after 5 data bytes, then a clean reload
                words_q = '{32'h1122_3344, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
                build_frame(16'd3, 1'b0);
                log_addr.delete(); log_data.delete();
                run_frame(1'b0, -1, 7, ed, ee);
                #1;
                rst_n = 1'b0;
                exp_addr_q.delete(); exp_data_q.delete();
                exp_last_addr = 32'd0; exp_last_data = 32'd0;
                #1;
                check_all_zero("t6_async_reset");
                check("t6_partial_nwr", 32'(log_addr.size()), 32'd1);
                @(negedge clk); @(negedge clk); #2;
                rst_n = 1'b1;
                @(posedge clk); #1;
                log_addr.delete(); log_data.delete();
                run_frame(1'b0, -1, 1000, ed, ee);
                finish_test("t6", ed, ee);
                check("t6_nwr", 32'(log_addr.size()), 32'd3);
                check("t6_done_lit", 32'(bus.out_done), 32'd1);

                sim_end = 1'b1;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
